// File: rtl/rtc_bcd_core.sv
`default_nettype none
// ============================================================================
// Module   : rtc_bcd_core
// Purpose  : BCD time-of-day core (hh:mm:ss). It runs on the system clock and
//            advances on an internal clock-enable tick. It has manual hour and
//            minute adjust buttons, a 12/24-hour mode, and an hourly chime of
//            configurable length.
// Optional : Define RTC_ALARM_EN to add the alarm compare/latch logic and
//            its ports.
// Params   : CLK_HZ, TICK_HZ  - tick period = CLK_HZ/TICK_HZ cycles (>= 2)
//            MODE_12H         - 0: hours 00..23, 1: hours 01..12 with pm flag
//            CHIME_SECS       - ticks the chime stays high (1..59)
// Ports    : clk, rst        - system clock, synchronous active-high reset
//            en              - run enable (freezes divider/time/chime when 0)
//            adj_hour/adj_min- asynchronous button levels, +1 per rising edge
//            hour/min/sec    - BCD fields, tens in [7:4], units in [3:0]
//            pm              - PM flag (12 h mode only, else 0)
//            tick            - one-cycle pulse per divider wrap
//            chime           - top-of-hour signal
//            alarm_*         - (RTC_ALARM_EN) alarm time, arm, ack inputs
//            alarm           - (RTC_ALARM_EN) alarm output
// Revision : 1.0 - initial release
// ============================================================================
module rtc_bcd_core #(
    parameter int CLK_HZ     = 100000000,
    parameter int TICK_HZ    = 1,
    parameter int MODE_12H   = 0,
    parameter int CHIME_SECS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       adj_hour,
    input  logic       adj_min,
`ifdef RTC_ALARM_EN
    input  logic [7:0] alarm_hour,
    input  logic [7:0] alarm_min,
    input  logic       alarm_pm,
    input  logic       alarm_arm,
    input  logic       alarm_ack,
    output logic       alarm,
`endif
    output logic [7:0] hour,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       pm,
    output logic       tick,
    output logic       chime
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_DIV_TC    = (CLK_HZ / TICK_HZ) - 1;
    localparam int                 c_DIV_W     = (c_DIV_TC > 1) ? $clog2(c_DIV_TC + 1) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_TC_V  = c_DIV_TC[c_DIV_W-1:0];
    localparam logic [7:0]         c_HOUR_RST  = (MODE_12H != 0) ? 8'h12 : 8'h00;
    localparam logic [5:0]         c_CHIME_LD  = CHIME_SECS[5:0];

    // ------------------------------------------------------------------------
    // BCD helpers
    // ------------------------------------------------------------------------
    // Two-digit BCD +1 (no field wrap; the caller handles the field limit).
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
        else                r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Seconds/minutes step: returns {carry, next}, 59 -> 00 with carry.
    function automatic logic [8:0] sixty_inc(input logic [7:0] v);
        logic [8:0] r;
        if (v == 8'h59) r = {1'b1, 8'h00};
        else            r = {1'b0, bcd_inc(v)};
        return r;
    endfunction

    // Hour step shared by the time advance and the hour button: returns {pm, hour}.
    function automatic logic [8:0] hour_step(input logic [7:0] h, input logic p);
        logic [8:0] r;
        if (MODE_12H != 0) begin
            if (h == 8'h11)      r = {~p, 8'h12};   // 11 -> 12 crosses noon/midnight
            else if (h == 8'h12) r = {p, 8'h01};
            else                 r = {p, bcd_inc(h)};
        end else begin
            if (h == 8'h23)      r = {1'b0, 8'h00};
            else                 r = {1'b0, bcd_inc(h)};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_DIV_W-1:0] div_q,    div_d;
    logic               tick_q,   tick_d;
    logic [7:0]         hour_q,   hour_d;
    logic [7:0]         min_q,    min_d;
    logic [7:0]         sec_q,    sec_d;
    logic               pm_q,     pm_d;
    logic               chime_q,  chime_d;
    logic [5:0]         ccnt_q,   ccnt_d;
    // Button synchronizer (two flops) plus the edge-detect history flop.
    logic [2:0]         hsync_q,  hsync_d;
    logic [2:0]         msync_q,  msync_d;
    logic               hpulse_q, hpulse_d;
    logic               mpulse_q, mpulse_d;
`ifdef RTC_ALARM_EN
    logic               alarm_q,  alarm_d;
    logic               adv_q,    adv_d;
    logic [5:0]         acnt_q,   acnt_d;
    logic               w_match;
`endif

    logic               w_adj_any;
    logic               w_sec_c;
    logic [7:0]         w_sec_n;
    logic               w_min_c;
    logic [7:0]         w_min_n;
    logic               w_pm_n;
    logic [7:0]         w_hour_n;
    logic               w_rollover;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        div_d    = div_q;
        tick_d   = 1'b0;
        hour_d   = hour_q;
        min_d    = min_q;
        sec_d    = sec_q;
        pm_d     = pm_q;
        chime_d  = chime_q;
        ccnt_d   = ccnt_q;

        // The button pulse is registered, so it appears 3 cycles after the
        // input edge (two sync stages plus the pulse flop).
        hsync_d  = {hsync_q[1:0], adj_hour};
        msync_d  = {msync_q[1:0], adj_min};
        hpulse_d = hsync_q[1] & ~hsync_q[2];
        mpulse_d = msync_q[1] & ~msync_q[2];

        w_adj_any            = hpulse_q | mpulse_q;
        {w_sec_c, w_sec_n}   = sixty_inc(sec_q);
        {w_min_c, w_min_n}   = sixty_inc(min_q);
        {w_pm_n, w_hour_n}   = hour_step(hour_q, pm_q);
        w_rollover           = tick_q & ~w_adj_any & w_sec_c & w_min_c;

        // Divider. A minute adjust restarts the second, so the divider is
        // cleared instead of wrapping. That case is not a wrap, so no tick.
        if (mpulse_q) begin
            div_d = '0;
        end else if (en) begin
            if (div_q == c_DIV_TC_V) begin
                div_d  = '0;
                tick_d = 1'b1;
            end else begin
                div_d  = div_q + c_DIV_W'(1);
            end
        end

        // Time fields. An adjust takes precedence and swallows a coincident
        // tick. The advance keys on tick_q alone: a tick that was already
        // emitted still counts even if en drops in that cycle.
        if (w_adj_any) begin
            if (mpulse_q) begin
                min_d = w_min_n;          // 59 -> 00, deliberately no hour carry
                sec_d = 8'h00;
            end
            if (hpulse_q) begin
                hour_d = w_hour_n;
                pm_d   = w_pm_n;
            end
        end else if (tick_q) begin
            sec_d = w_sec_n;
            if (w_sec_c) begin
                min_d = w_min_n;
                if (w_min_c) begin
                    hour_d = w_hour_n;
                    pm_d   = w_pm_n;
                end
            end
        end

        // Chime. Only a natural top-of-hour (re)loads the countdown. The
        // countdown steps on each tick after that, and the chime drops once
        // the count reaches zero.
        if (w_rollover) begin
            chime_d = 1'b1;
            ccnt_d  = c_CHIME_LD;
        end else if (tick_q && chime_q) begin
            ccnt_d = ccnt_q - 6'd1;
            if (ccnt_q == 6'd1) chime_d = 1'b0;
        end

`ifdef RTC_ALARM_EN
        // adv_q marks the cycle where a tick-driven update becomes visible,
        // so adjust-driven matches are ignored.
        adv_d   = tick_q & ~w_adj_any;
        alarm_d = alarm_q;
        acnt_d  = acnt_q;
        w_match = adv_q && (sec_q == 8'h00) && (hour_q == alarm_hour) &&
                  (min_q == alarm_min) && ((MODE_12H == 0) || (pm_q == alarm_pm));
        if (alarm_q) begin
            if (alarm_ack || !alarm_arm) begin
                alarm_d = 1'b0;
            end else if (tick_q) begin
                acnt_d = acnt_q + 6'd1;
                if (acnt_q == 6'd59) alarm_d = 1'b0;   // 60th tick since set
            end
        end else if (w_match && alarm_arm && !alarm_ack) begin
            alarm_d = 1'b1;
            acnt_d  = 6'd0;
        end
`endif
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            tick_q   <= 1'b0;
            hour_q   <= c_HOUR_RST;
            min_q    <= 8'h00;
            sec_q    <= 8'h00;
            pm_q     <= 1'b0;
            chime_q  <= 1'b0;
            ccnt_q   <= 6'd0;
            hsync_q  <= 3'b000;
            msync_q  <= 3'b000;
            hpulse_q <= 1'b0;
            mpulse_q <= 1'b0;
`ifdef RTC_ALARM_EN
            alarm_q  <= 1'b0;
            adv_q    <= 1'b0;
            acnt_q   <= 6'd0;
`endif
        end else begin
            div_q    <= div_d;
            tick_q   <= tick_d;
            hour_q   <= hour_d;
            min_q    <= min_d;
            sec_q    <= sec_d;
            pm_q     <= pm_d;
            chime_q  <= chime_d;
            ccnt_q   <= ccnt_d;
            hsync_q  <= hsync_d;
            msync_q  <= msync_d;
            hpulse_q <= hpulse_d;
            mpulse_q <= mpulse_d;
`ifdef RTC_ALARM_EN
            alarm_q  <= alarm_d;
            adv_q    <= adv_d;
            acnt_q   <= acnt_d;
`endif
        end
    end

    assign hour  = hour_q;
    assign min   = min_q;
    assign sec   = sec_q;
    assign pm    = (MODE_12H != 0) ? pm_q : 1'b0;
    assign tick  = tick_q;
    assign chime = chime_q;
`ifdef RTC_ALARM_EN
    assign alarm = alarm_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rtc_bcd_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_bcd_core
// Purpose  : Directed, self-checking bench for rtc_bcd_core. It uses one
//            24 h instance and one 12 h instance, both with a 10-cycle tick.
//            A table of adjust vectors is followed by timed sequences for
//            rollover, chime, freeze, adjust/tick collision and the alarm
//            (the alarm sequence is built only when RTC_ALARM_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_bcd_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en24, ah24, am24, en12, ah12, am12;
    logic [7:0] hour24, min24, sec24, hour12, min12, sec12;
    logic       pm24, tick24, chime24, pm12, tick12, chime12;
`ifdef RTC_ALARM_EN
    logic [7:0] al_hour, al_min;
    logic       al_pm, al_arm, al_ack, alarm24, alarm12;
`endif

    rtc_bcd_core #(.CLK_HZ(10), .TICK_HZ(1), .MODE_12H(0), .CHIME_SECS(3)) u_dut24 (
        .clk(clk), .rst(rst), .en(en24), .adj_hour(ah24), .adj_min(am24),
`ifdef RTC_ALARM_EN
        .alarm_hour(al_hour), .alarm_min(al_min), .alarm_pm(al_pm),
        .alarm_arm(al_arm), .alarm_ack(al_ack), .alarm(alarm24),
`endif
        .hour(hour24), .min(min24), .sec(sec24), .pm(pm24), .tick(tick24), .chime(chime24)
    );

    rtc_bcd_core #(.CLK_HZ(10), .TICK_HZ(1), .MODE_12H(1), .CHIME_SECS(3)) u_dut12 (
        .clk(clk), .rst(rst), .en(en12), .adj_hour(ah12), .adj_min(am12),
`ifdef RTC_ALARM_EN
        .alarm_hour(al_hour), .alarm_min(al_min), .alarm_pm(al_pm),
        .alarm_arm(al_arm), .alarm_ack(al_ack), .alarm(alarm12),
`endif
        .hour(hour12), .min(min12), .sec(sec12), .pm(pm12), .tick(tick12), .chime(chime12)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        en24 = 1'b0; en12 = 1'b0;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        rst  = 1'b0;
    endtask

    // One button press: high 2 cycles, then low long enough for the
    // synchronized pulse to land and the next press to be seen as a new edge.
    task automatic press(input bit sel12, input bit h, input bit m);
        if (sel12) begin ah12 = h; am12 = m; end
        else       begin ah24 = h; am24 = m; end
        repeat (2) @(negedge clk);
        ah12 = 1'b0; am12 = 1'b0; ah24 = 1'b0; am24 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        bit         sel12;
        bit         h;
        bit         m;
        int         n;
        logic [7:0] e_hour;
        logic [7:0] e_min;
        logic [7:0] e_sec;
        logic       e_pm;
    } adj_vec_t;

    localparam int NV = 18;
    adj_vec_t vecs [NV];

    int          ticks, badpos, chime_cnt, first_chime, next_tick, frz_bad, chime_seen;
    logic [63:0] snap;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // sel12, h, m, presses, expected hour, min, sec, pm (cumulative per DUT)
        vecs[0]  = '{1'b0, 1'b0, 1'b1,  1, 8'h00, 8'h01, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0,  1, 8'h01, 8'h01, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1,  1, 8'h02, 8'h02, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 21, 8'h23, 8'h02, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0,  1, 8'h00, 8'h02, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 57, 8'h00, 8'h59, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1,  1, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 23, 8'h23, 8'h00, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 59, 8'h23, 8'h59, 8'h00, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0,  1, 8'h01, 8'h00, 8'h00, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 10, 8'h11, 8'h00, 8'h00, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0,  1, 8'h12, 8'h00, 8'h00, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b0,  1, 8'h01, 8'h00, 8'h00, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 10, 8'h11, 8'h00, 8'h00, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b0,  1, 8'h12, 8'h00, 8'h00, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b1,  1, 8'h01, 8'h01, 8'h00, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 10, 8'h11, 8'h01, 8'h00, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 58, 8'h11, 8'h59, 8'h00, 1'b0};

        ah24 = 1'b0; am24 = 1'b0; ah12 = 1'b0; am12 = 1'b0;
`ifdef RTC_ALARM_EN
        al_hour = 8'h00; al_min = 8'h01; al_pm = 1'b0; al_arm = 1'b0; al_ack = 1'b0;
`endif
        en24 = 1'b0; en12 = 1'b0;
        rst  = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state (sampled while rst is still asserted)
        check("rst24", 64'({hour24, min24, sec24, pm24, tick24, chime24}), 64'({24'h000000, 3'b000}));
        check("rst12", 64'({hour12, min12, sec12, pm12, tick12, chime12}), 64'({24'h120000, 3'b000}));

        // Free run: ticks every 10 cycles, 10 s after 100 cycles
        rst = 1'b0; en24 = 1'b1;
        ticks = 0; badpos = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (tick24) begin
                ticks++;
                if (k % 10 != 0) badpos++;
            end
        end
        en24 = 1'b0;
        check("run_ticks", 64'(ticks), 64'(10));
        check("run_tick_pos", 64'(badpos), 64'(0));
        @(negedge clk);
        check("run_time", 64'({hour24, min24, sec24}), 64'(24'h000010));

        // Adjust vectors (en = 0 so no ticks interfere)
        do_reset();
        for (int i = 0; i < NV; i++) begin
            for (int j = 0; j < vecs[i].n; j++) press(vecs[i].sel12, vecs[i].h, vecs[i].m);
            if (vecs[i].sel12)
                check($sformatf("adj%0d", i), 64'({hour12, min12, sec12, pm12, chime12}),
                      64'({vecs[i].e_hour, vecs[i].e_min, vecs[i].e_sec, vecs[i].e_pm, 1'b0}));
            else
                check($sformatf("adj%0d", i), 64'({hour24, min24, sec24, pm24, chime24}),
                      64'({vecs[i].e_hour, vecs[i].e_min, vecs[i].e_sec, vecs[i].e_pm, 1'b0}));
        end

        // 23:59:00 -> 23:59:59 -> 00:00:00, chime for 3 ticks
        en24 = 1'b1; chime_cnt = 0; first_chime = -1;
        for (int k = 1; k <= 640; k++) begin
            @(negedge clk);
            if (k == 600) check("day_pre", 64'({hour24, min24, sec24, tick24, chime24}), 64'({24'h235959, 2'b10}));
            if (k == 601) check("day_roll", 64'({hour24, min24, sec24, chime24}), 64'({24'h000000, 1'b1}));
            if (chime24) begin
                chime_cnt++;
                if (first_chime < 0) first_chime = k;
            end
        end
        en24 = 1'b0;
        check("chime_len", 64'(chime_cnt), 64'(30));
        check("chime_start", 64'(first_chime), 64'(601));

        // Minute adjust landing on the same cycle as the tick at 00:59:59
        for (int j = 0; j < 59; j++) press(1'b0, 1'b0, 1'b1);
        check("coll_setup", 64'({hour24, min24, sec24}), 64'(24'h005900));
        en24 = 1'b1; next_tick = -1; chime_seen = 0;
        for (int k = 1; k <= 630; k++) begin
            @(negedge clk);
            if (k == 600) check("coll_pre", 64'({hour24, min24, sec24, tick24}), 64'({24'h005959, 1'b1}));
            if (k == 601) check("coll_adj", 64'({hour24, min24, sec24, chime24}), 64'({24'h000000, 1'b0}));
            if (k > 601 && tick24 && next_tick < 0) next_tick = k;
            if (k >= 601 && chime24) chime_seen++;
            if (k == 597) am24 = 1'b1;   // pulse lands 3 cycles later, on the tick
            if (k == 599) am24 = 1'b0;
        end
        en24 = 1'b0;
        // Adjusted time is visible at 601; the next tick is 10 cycles on.
        check("coll_next_tick", 64'(next_tick), 64'(611));
        check("coll_no_chime", 64'(chime_seen), 64'(0));

        // 12 h: 11:59:59 am -> 12:00:00 pm, with a 47-cycle freeze mid-chime
        en12 = 1'b1; chime_cnt = 0; next_tick = -1; frz_bad = 0; snap = '0;
        for (int k = 1; k <= 700; k++) begin
            @(negedge clk);
            if (k == 600) check("noon_pre", 64'({hour12, min12, sec12, pm12, tick12}), 64'({24'h115959, 2'b01}));
            if (k == 601) check("noon_roll", 64'({hour12, min12, sec12, pm12, chime12}), 64'({24'h120000, 2'b11}));
            if (chime12) chime_cnt++;
            if (k > 613 && k <= 660) begin
                if (tick12) frz_bad++;
                if (64'({hour12, min12, sec12, pm12, chime12}) != snap) frz_bad++;
            end
            if (k > 660 && tick12 && next_tick < 0) next_tick = k;
            if (k == 613) begin
                snap = 64'({hour12, min12, sec12, pm12, chime12});
                en12 = 1'b0;
            end
            if (k == 660) en12 = 1'b1;
        end
        en12 = 1'b0;
        check("freeze_hold", 64'(frz_bad), 64'(0));
        check("freeze_resume_tick", 64'(next_tick), 64'(667));
        check("freeze_chime_len", 64'(chime_cnt), 64'(77));

        // 12:59:59 pm -> 01:00:00 pm (no pm toggle)
        for (int j = 0; j < 59; j++) press(1'b1, 1'b0, 1'b1);
        check("one_setup", 64'({hour12, min12, sec12, pm12}), 64'({24'h125900, 1'b1}));
        en12 = 1'b1;
        for (int k = 1; k <= 601; k++) begin
            @(negedge clk);
            if (k == 600) check("one_pre", 64'({hour12, min12, sec12, pm12}), 64'({24'h125959, 1'b1}));
            if (k == 601) check("one_roll", 64'({hour12, min12, sec12, pm12, chime12}), 64'({24'h010000, 2'b11}));
        end
        en12 = 1'b0;

`ifdef RTC_ALARM_EN
        // Alarm at 00:01, acknowledged
        do_reset();
        al_arm = 1'b1; en24 = 1'b1;
        for (int k = 1; k <= 610; k++) begin
            @(negedge clk);
            if (k == 601) check("alm_land", 64'({hour24, min24, sec24, alarm24}), 64'({24'h000100, 1'b0}));
            if (k == 602) check("alm_set", 64'(alarm24), 64'(1));
            if (k == 605) begin
                check("alm_hold", 64'(alarm24), 64'(1));
                al_ack = 1'b1;
            end
            if (k == 606) begin
                check("alm_ack", 64'(alarm24), 64'(0));
                al_ack = 1'b0;
            end
        end
        // Same alarm, never acknowledged: clears after 60 ticks
        do_reset();
        en24 = 1'b1;
        for (int k = 1; k <= 1205; k++) begin
            @(negedge clk);
            if (k == 602)  check("alm2_set", 64'(alarm24), 64'(1));
            if (k == 1200) check("alm2_last", 64'(alarm24), 64'(1));
            if (k == 1201) check("alm2_clear", 64'(alarm24), 64'(0));
        end
        en24 = 1'b0; al_arm = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rtc_bcd_core.md
Name: rtc_bcd_core

Overview:
Parametrised BCD time-of-day core for the multi-function digital clock board: hour/min/sec counters, manual adjust and hourly chime.
- Generalises the fixed 1 Hz clock: runs on the system clock with an internal clock-enable tick, not a derived clock.
- Adds a 12/24-hour mode and a configurable chime length.
- Outputs feed the existing 7-segment display driver unchanged: 2 BCD digits per field.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz.
TICK_HZ, 1, time-advance rate; divider terminal count = CLK_HZ/TICK_HZ - 1. The ratio must be an integer >= 2.
MODE_12H, 0, 0 = hours 00..23; 1 = hours 01..12 with a pm flag.
CHIME_SECS, 3, number of ticks the chime stays high after each natural top-of-hour, range 1..59.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  run enable; 0 freezes the divider, time and chime countdown.
adj_hour  in  1  asynchronous button level; each rising edge adds one hour.
adj_min  in  1  asynchronous button level; each rising edge adds one minute.
hour  out  8  BCD hours, tens in [7:4] and units in [3:0].
min  out  8  BCD minutes.
sec  out  8  BCD seconds.
pm  out  1  PM flag in 12 h mode; constant 0 when MODE_12H = 0.
tick  out  1  one-cycle pulse each time the divider wraps.
chime  out  1  top-of-hour signal.

Behaviour:
Clocking and reset:
- One clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: divider 0, sec 0x00, min 0x00, chime 0, tick 0, pm 0. hour is 0x00 in 24 h mode and 0x12 in 12 h mode.
Divider:
- The divider increments only when en = 1.
- At the terminal count it wraps to 0. tick is registered and high for exactly the cycle after the wrap.
- The divider holds its value while en = 0, so no partial second is lost.
Time advance (applied on a cycle with tick = 1):
- sec advances +1 in BCD; 59 -> 00 carries into min.
- min 59 -> 00 carries into hour.
- 24 h mode: hour 23 -> 00.
- 12 h mode: hour 11 -> 12 toggles pm; 12 -> 01 with no pm change; otherwise +1.
- Non-BCD digit codes never occur.
Adjust inputs:
- Each button goes through a 2-flop synchronizer, then a rising-edge detect; a one-cycle internal pulse is taken 3 cycles after the input edge.
- Adjust works regardless of en.
- adj_min pulse: min +1 with wrap 59 -> 00 and no hour carry; sec <= 00; divider <= 0.
- adj_hour pulse: hour +1 with the same wrap rules as the time-advance hour step, including the 12 h pm toggle; min and sec are unchanged.
- Both pulses in the same cycle: both fields are applied.
- Priority: if any adjust pulse coincides with a tick, the adjust is applied and that tick's time advance is dropped.
Chime:
- Armed only by a tick-driven min 59 -> 00 rollover.
- chime goes high the cycle after the rollover and loads a countdown of CHIME_SECS.
- The countdown decrements on each subsequent tick. chime drops in the cycle after the tick that reaches 0, i.e. it is high for CHIME_SECS ticks.
- Adjust-caused 00 minutes never start a chime.
- A new rollover during an active chime reloads the countdown.
- rst mid-chime clears it immediately.

Optional Feature:
Macro: RTC_ALARM_EN.
When defined, these ports are added:
- alarm_hour in 8 (BCD, same format as hour).
- alarm_min in 8 (BCD).
- alarm_pm in 1 (ignored in 24 h mode).
- alarm_arm in 1.
- alarm_ack in 1.
- alarm out 1, reset value 0.
Alarm behaviour:
- alarm sets the cycle after a tick-driven update lands on sec = 00 with hour/min/pm equal to the alarm inputs while alarm_arm = 1.
- alarm clears the cycle after any of: alarm_ack = 1 (level), alarm_arm = 0, or 60 further ticks.
- Adjust-driven matches do not trigger the alarm.
When the macro is not defined, those ports and all alarm logic are absent, and the module is otherwise identical.

Test Plan:
All scenarios use CLK_HZ = 10, TICK_HZ = 1 (tick every 10 cycles) unless stated.
1. Reset, then en = 1 for 100 cycles -> tick pulses at cycles 10, 20, ..., 100; sec = 0x10; min = hour = 0x00.
2. 23 adj_hour edges, 59 adj_min edges, then 60 ticks -> 23:59:59 -> 00:00:00 on tick 60; chime high for exactly 3 ticks (30 cycles), then 0.
3. MODE_12H = 1: reach 11:59:59 with pm = 0 and tick -> 12:00:00, pm = 1; later 12:59:59 and tick -> 01:00:00, pm still 1.
4. en = 0 for 47 cycles mid-second -> hour, min, sec, divider and chime all frozen; en = 1 -> next tick arrives after exactly the remaining cycles of the interrupted second.
5. At 00:59:59, adj_min pulse coincides with tick -> 00:00:00 (hour unchanged, sec 00), no chime, next tick 10 cycles later.
6. RTC_ALARM_EN, alarm 00:01 armed -> alarm = 1 the cycle after sec reaches 00 at 00:01:00; alarm_ack pulse -> alarm = 0 next cycle. Unacked repeat run -> alarm clears after 60 ticks.
